// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC conversion sequencer:
//   seq_state_t  - FSM state encoding (IDLE, TRIG, WAIT_DATA, GAP)
//   MIN_PERIOD   - smallest cnv_o spacing the sequencer will honour
//   timer_width  - width needed to hold a given terminal count
// ---------------------------------------------------------------------------
package adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_GAP       = 2'd3
  } seq_state_t;

  // One cycle for TRIG plus at least one cycle of WAIT_DATA.
  localparam int unsigned MIN_PERIOD = 2;

  // Bits required to store max_val; never less than one.
  function automatic int unsigned timer_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// ---------------------------------------------------------------------------
// adc_seq_timer
// Loadable saturating down-counter used for both the cnv_o period and the
// sample-return timeout.
//   clk_adc    in   clock
//   rst        in   asynchronous active-high reset, clears the count
//   load       in   load load_val (has priority over dec)
//   load_val   in   value to load
//   dec        in   decrement by one, holding at zero
//   zero_next  out  count will be zero once this cycle's decrement is applied
// ---------------------------------------------------------------------------
module adc_seq_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_adc,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // The FSM decides its next state in the same cycle the counter steps, so
  // it needs to know whether the count lands on zero, not whether it is
  // already there. A count of 1 (about to hit zero) or 0 (saturated) both
  // qualify.
  assign zero_next = (count_reg <= WIDTH'(1));

endmodule

// File: rtl/adc_cnv_sequencer.sv
// ---------------------------------------------------------------------------
// adc_cnv_sequencer
// Issues periodic one-cycle conversion triggers to an SPI ADC read stage,
// collects the returned samples, and ends the run after a burst count, on
// stop, or on a sample-return timeout.
//   clk_adc         in   clock, all logic on rising edge
//   rst             in   asynchronous active-high reset
//   start_i         in   begin a run (ignored while busy, loses to stop_i)
//   stop_i          in   end the run
//   period_i        in   cycles between cnv_o pulses (clamped to >= 2)
//   burst_i         in   conversions per run, 0 = continuous
//   cnv_o           out  one-cycle conversion trigger
//   sdi_valid_i     in   sample-valid strobe from the read stage
//   sdi_data_i      in   sample from the read stage
//   sample_o        out  registered sample
//   sample_valid_o  out  one-cycle strobe qualifying sample_o
//   sample_last_o   out  final sample of the run, with sample_valid_o
//   busy_o          out  high whenever not IDLE
//   timeout_o       out  sticky: a conversion timed out
//   count_o         out  samples delivered in the current/last run
// ---------------------------------------------------------------------------
module adc_cnv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned BURST_W     = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk_adc,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic [BURST_W-1:0]    burst_i,
  output logic                  cnv_o,
  input  logic                  sdi_valid_i,
  input  logic [DATA_WIDTH-1:0] sdi_data_i,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid_o,
  output logic                  sample_last_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [BURST_W-1:0]    count_o
);

  localparam int unsigned TO_W = timer_width(TIMEOUT_CYC);

  seq_state_t            state_reg,        state_next;
  logic [PERIOD_W-1:0]   period_lat_reg,   period_lat_next;
  logic [BURST_W-1:0]    burst_lat_reg,    burst_lat_next;
  logic [BURST_W-1:0]    count_reg,        count_next;
  logic                  timeout_reg,      timeout_next;
  logic                  stop_pend_reg,    stop_pend_next;
  logic [DATA_WIDTH-1:0] sample_reg,       sample_next;
  logic                  sample_valid_reg, sample_valid_next;
  logic                  sample_last_reg,  sample_last_next;

  logic                  timers_load;
  logic                  timers_dec;
  logic                  period_zero_next;
  logic                  timeout_zero_next;
  logic [BURST_W-1:0]    count_inc;
  logic                  run_last;

  // -------------------------------------------------------------------------
  // Timers: both reload on every trigger and run only while waiting for data
  // or idling between conversions.
  // -------------------------------------------------------------------------
  assign timers_dec = (state_reg == ST_WAIT_DATA) || (state_reg == ST_GAP);

  adc_seq_timer #(
    .WIDTH (PERIOD_W)
  ) u_period_timer (
    .clk_adc   (clk_adc),
    .rst       (rst),
    .load      (timers_load),
    .load_val  (period_lat_reg - 1'b1),
    .dec       (timers_dec),
    .zero_next (period_zero_next)
  );

  adc_seq_timer #(
    .WIDTH (TO_W)
  ) u_timeout_timer (
    .clk_adc   (clk_adc),
    .rst       (rst),
    .load      (timers_load),
    .load_val  (TO_W'(TIMEOUT_CYC)),
    .dec       (timers_dec),
    .zero_next (timeout_zero_next)
  );

  // Count wraps naturally in continuous mode.
  assign count_inc = count_reg + 1'b1;

  // A stop arriving in the same cycle as the sample also closes the run,
  // since that conversion is the one being finished.
  assign run_last = ((burst_lat_reg != '0) && (count_inc == burst_lat_reg))
                    || stop_pend_reg || stop_i;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      period_lat_reg   <= PERIOD_W'(MIN_PERIOD);
      burst_lat_reg    <= '0;
      count_reg        <= '0;
      timeout_reg      <= 1'b0;
      stop_pend_reg    <= 1'b0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
      sample_last_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      period_lat_reg   <= period_lat_next;
      burst_lat_reg    <= burst_lat_next;
      count_reg        <= count_next;
      timeout_reg      <= timeout_next;
      stop_pend_reg    <= stop_pend_next;
      sample_reg       <= sample_next;
      sample_valid_reg <= sample_valid_next;
      sample_last_reg  <= sample_last_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    period_lat_next   = period_lat_reg;
    burst_lat_next    = burst_lat_reg;
    count_next        = count_reg;
    timeout_next      = timeout_reg;
    stop_pend_next    = stop_pend_reg;
    sample_next       = sample_reg;
    sample_valid_next = 1'b0;
    sample_last_next  = 1'b0;
    timers_load       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        stop_pend_next = 1'b0;
        if (start_i && !stop_i) begin
          if (period_i < PERIOD_W'(MIN_PERIOD)) begin
            period_lat_next = PERIOD_W'(MIN_PERIOD);
          end else begin
            period_lat_next = period_i;
          end
          burst_lat_next = burst_i;
          count_next     = '0;
          timeout_next   = 1'b0;
          state_next     = ST_TRIG;
        end
      end

      ST_TRIG: begin
        // cnv_o is high for this cycle no matter what; stop only prevents
        // waiting for its data.
        timers_load = 1'b1;
        state_next  = stop_i ? ST_IDLE : ST_WAIT_DATA;
      end

      ST_WAIT_DATA: begin
        if (sdi_valid_i) begin
          sample_next       = sdi_data_i;
          sample_valid_next = 1'b1;
          sample_last_next  = run_last;
          count_next        = count_inc;
          if (run_last) begin
            state_next = ST_IDLE;
          end else if (period_zero_next) begin
            state_next = ST_TRIG;
          end else begin
            state_next = ST_GAP;
          end
        end else if (timeout_zero_next) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (stop_i) begin
          stop_pend_next = 1'b1;
        end
      end

      ST_GAP: begin
        if (stop_i) begin
          state_next = ST_IDLE;
        end else if (period_zero_next) begin
          state_next = ST_TRIG;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cnv_o          = (state_reg == ST_TRIG);
  assign busy_o         = (state_reg != ST_IDLE);
  assign sample_o       = sample_reg;
  assign sample_valid_o = sample_valid_reg;
  assign sample_last_o  = sample_last_reg;
  assign timeout_o      = timeout_reg;
  assign count_o        = count_reg;

endmodule

// File: tb/tb_adc_cnv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_cnv_sequencer
// Directed bench for adc_cnv_sequencer. A responder process answers each
// cnv_o with sdi_valid_i after a programmable delay; a monitor logs every
// cnv_o and sample with its cycle number for the directed steps to check.
// ---------------------------------------------------------------------------
module tb_adc_cnv_sequencer;

  localparam int DW = 16;
  localparam int PW = 16;
  localparam int BW = 16;
  localparam int TO = 255;

  logic          clk_adc = 1'b0;
  logic          rst;
  logic          start_i;
  logic          stop_i;
  logic [PW-1:0] period_i;
  logic [BW-1:0] burst_i;
  logic          cnv_o;
  logic          sdi_valid_i;
  logic [DW-1:0] sdi_data_i;
  logic [DW-1:0] sample_o;
  logic          sample_valid_o;
  logic          sample_last_o;
  logic          busy_o;
  logic          timeout_o;
  logic [BW-1:0] count_o;

  adc_cnv_sequencer #(
    .DATA_WIDTH  (DW),
    .PERIOD_W    (PW),
    .BURST_W     (BW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_adc        (clk_adc),
    .rst            (rst),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .period_i       (period_i),
    .burst_i        (burst_i),
    .cnv_o          (cnv_o),
    .sdi_valid_i    (sdi_valid_i),
    .sdi_data_i     (sdi_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_last_o  (sample_last_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o),
    .count_o        (count_o)
  );

  always #5 clk_adc = ~clk_adc;

  int cyc = 0;
  always @(posedge clk_adc) cyc <= cyc + 1;

  // Monitor logs
  int            cnv_cyc[$];
  int            smp_cyc[$];
  logic [DW-1:0] smp_data[$];
  logic          smp_last[$];

  always @(negedge clk_adc) begin
    if (cnv_o === 1'b1) begin
      cnv_cyc.push_back(cyc);
      $display("cyc %0d: cnv_o", cyc);
    end
    if (sample_valid_o === 1'b1) begin
      smp_cyc.push_back(cyc);
      smp_data.push_back(sample_o);
      smp_last.push_back(sample_last_o);
      $display("cyc %0d: sample %h last=%0b count=%0d", cyc, sample_o, sample_last_o, count_o);
    end
  end

  // Responder: data values run 1000, 1001, ... in order of return
  bit            resp_en    = 1'b0;
  int            resp_delay = 4;
  int            stray_req  = 0;
  int            stray_done = 0;

  initial begin
    int            resp_cnt;
    logic [DW-1:0] resp_data;
    resp_cnt    = 0;
    resp_data   = 16'h1000;
    sdi_valid_i = 1'b0;
    sdi_data_i  = '0;
    forever begin
      @(posedge clk_adc);
      #1;
      sdi_valid_i = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          sdi_valid_i = 1'b1;
          sdi_data_i  = resp_data;
          resp_data++;
        end
      end else if (stray_req != stray_done) begin
        stray_done  = stray_req;
        sdi_valid_i = 1'b1;
        sdi_data_i  = 16'hDEAD;
      end
      if (cnv_o === 1'b1 && resp_en) resp_cnt = resp_delay;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_adc);
      #1;
    end
  endtask

  function automatic int cnv_at(input int i);
    return (i < cnv_cyc.size()) ? cnv_cyc[i] : -1;
  endfunction

  function automatic int scyc_at(input int i);
    return (i < smp_cyc.size()) ? smp_cyc[i] : -1;
  endfunction

  function automatic logic [DW-1:0] sdata_at(input int i);
    return (i < smp_data.size()) ? smp_data[i] : 16'hFFFF;
  endfunction

  function automatic logic slast_at(input int i);
    return (i < smp_last.size()) ? smp_last[i] : 1'bx;
  endfunction

  task automatic clear_logs();
    cnv_cyc.delete();
    smp_cyc.delete();
    smp_data.delete();
    smp_last.delete();
  endtask

  initial begin
    int            s;
    logic [DW-1:0] exp_data;
    exp_data = 16'h1000;
    rst      = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    period_i = '0;
    burst_i  = '0;
    tick(3);

    // Reset state
    check("rst_cnv", cnv_o, 0);
    check("rst_svalid", sample_valid_o, 0);
    check("rst_slast", sample_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_count", count_o, 0);
    check("rst_sample", sample_o, 0);
    rst = 1'b0;
    tick(2);

    // period=10 burst=3, data 4 cycles after cnv; mid-run input changes and
    // a start while busy must not disturb the run
    clear_logs();
    period_i = 10; burst_i = 3; resp_en = 1'b1; resp_delay = 4;
    start_i = 1'b1; s = cyc; tick(1); start_i = 1'b0;
    period_i = 3; burst_i = 1;
    tick(2);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(35);
    check("t1_ncnv", cnv_cyc.size(), 3);
    check("t1_cnv0", cnv_at(0), s + 1);
    check("t1_cnv1", cnv_at(1), s + 11);
    check("t1_cnv2", cnv_at(2), s + 21);
    check("t1_nsmp", smp_cyc.size(), 3);
    check("t1_scyc0", scyc_at(0), s + 6);
    check("t1_d0", sdata_at(0), exp_data);
    check("t1_d2", sdata_at(2), exp_data + 2);
    check("t1_last0", slast_at(0), 0);
    check("t1_last1", slast_at(1), 0);
    check("t1_last2", slast_at(2), 1);
    check("t1_count", count_o, 3);
    check("t1_busy", busy_o, 0);
    exp_data = exp_data + 3;

    // period=4, data 6 cycles after cnv: retrigger right after each sample
    clear_logs();
    period_i = 4; burst_i = 3; resp_delay = 6;
    start_i = 1'b1; s = cyc; tick(1); start_i = 1'b0;
    tick(30);
    check("t2_ncnv", cnv_cyc.size(), 3);
    check("t2_cnv1", cnv_at(1), s + 8);
    check("t2_cnv2", cnv_at(2), s + 15);
    check("t2_nsmp", smp_cyc.size(), 3);
    check("t2_scyc2", scyc_at(2), s + 22);
    check("t2_d2", sdata_at(2), exp_data + 2);
    check("t2_last2", slast_at(2), 1);
    check("t2_count", count_o, 3);
    exp_data = exp_data + 3;

    // continuous run, stop during the second WAIT_DATA
    clear_logs();
    period_i = 10; burst_i = 0; resp_delay = 4;
    start_i = 1'b1; s = cyc; tick(1); start_i = 1'b0;
    tick(12);
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
    tick(30);
    check("t3_ncnv", cnv_cyc.size(), 2);
    check("t3_nsmp", smp_cyc.size(), 2);
    check("t3_last0", slast_at(0), 0);
    check("t3_last1", slast_at(1), 1);
    check("t3_scyc1", scyc_at(1), s + 16);
    check("t3_d1", sdata_at(1), exp_data + 1);
    check("t3_count", count_o, 2);
    check("t3_busy", busy_o, 0);
    exp_data = exp_data + 2;

    // no data returned: timeout after 255 cycles
    clear_logs();
    period_i = 10; burst_i = 1; resp_en = 1'b0;
    start_i = 1'b1; s = cyc; tick(1); start_i = 1'b0;
    tick(255);
    check("t4_to_early", timeout_o, 0);
    check("t4_busy_early", busy_o, 1);
    tick(1);
    check("t4_to_set", timeout_o, 1);
    check("t4_busy_done", busy_o, 0);
    check("t4_nsmp", smp_cyc.size(), 0);
    check("t4_ncnv", cnv_cyc.size(), 1);
    resp_en = 1'b1; resp_delay = 4;
    start_i = 1'b1; tick(1); start_i = 1'b0;
    check("t4_to_clr", timeout_o, 0);
    check("t4_busy_new", busy_o, 1);
    tick(10);
    check("t4_d_new", sdata_at(0), exp_data);
    check("t4_last_new", slast_at(0), 1);
    exp_data = exp_data + 1;

    // reset during GAP of a burst=5 run
    clear_logs();
    period_i = 10; burst_i = 5; resp_delay = 4;
    start_i = 1'b1; s = cyc; tick(1); start_i = 1'b0;
    tick(6);
    check("t5_pre_busy", busy_o, 1);
    check("t5_pre_count", count_o, 1);
    rst = 1'b1;
    #1;
    check("t5_cnv", cnv_o, 0);
    check("t5_svalid", sample_valid_o, 0);
    check("t5_slast", sample_last_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_timeout", timeout_o, 0);
    check("t5_count", count_o, 0);
    check("t5_sample", sample_o, 0);
    tick(2);
    rst = 1'b0;
    clear_logs();
    tick(30);
    check("t5_ncnv_after", cnv_cyc.size(), 0);
    check("t5_nsmp_after", smp_cyc.size(), 0);
    check("t5_busy_after", busy_o, 0);
    exp_data = exp_data + 1;

    // start+stop together: no run; stray sdi_valid in IDLE ignored;
    // then period=1 clamps to 2
    clear_logs();
    period_i = 1; burst_i = 3; resp_delay = 1;
    start_i = 1'b1; stop_i = 1'b1; tick(1); start_i = 1'b0; stop_i = 1'b0;
    tick(5);
    check("t6_busy_ss", busy_o, 0);
    check("t6_ncnv_ss", cnv_cyc.size(), 0);
    stray_req = stray_req + 1;
    tick(4);
    check("t6_stray", smp_cyc.size(), 0);
    start_i = 1'b1; s = cyc; tick(1); start_i = 1'b0;
    tick(15);
    check("t6_ncnv", cnv_cyc.size(), 3);
    check("t6_cnv0", cnv_at(0), s + 1);
    check("t6_cnv1", cnv_at(1), s + 3);
    check("t6_cnv2", cnv_at(2), s + 5);
    check("t6_nsmp", smp_cyc.size(), 3);
    check("t6_last2", slast_at(2), 1);
    check("t6_d2", sdata_at(2), exp_data + 2);
    check("t6_count", count_o, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_cnv_sequencer.md
ADC_CNV_SEQUENCER -- requirements
Module: adc_cnv_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, ADC sample width.
REQ-002 SHALL have parameter PERIOD_W, default 16, width of period_i and the period counter.
REQ-003 SHALL have parameter BURST_W, default 16, width of burst_i and count_o.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, maximum cycles from cnv_o to sdi_valid_i before abort.
REQ-005 SHALL have these ports: clk_adc  in  1  sole clock, all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start_i  in  1  single-cycle request to begin a conversion run.
REQ-008 stop_i  in  1  single-cycle request to end the run.
REQ-009 period_i  in  PERIOD_W  cycles between successive cnv_o pulses.
REQ-010 burst_i  in  BURST_W  conversions per run; 0 = continuous.
REQ-011 cnv_o  out  1  one-cycle conversion trigger to the SPI read stage (its sdi_ready input).
REQ-012 sdi_valid_i  in  1  sample-valid strobe from the SPI read stage.
REQ-013 sdi_data_i  in  DATA_WIDTH  sample from the SPI read stage.
REQ-014 sample_o  out  DATA_WIDTH  registered sample.
REQ-015 sample_valid_o  out  1  one-cycle strobe qualifying sample_o.
REQ-016 sample_last_o  out  1  marks the final sample of a run, valid with sample_valid_o.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 timeout_o  out  1  sticky flag, set when a conversion times out.
REQ-019 count_o  out  BURST_W  samples delivered in the current or last run.

Function
REQ-020 SHALL implement FSM states IDLE, TRIG, WAIT_DATA, GAP.
REQ-021 IDLE: on start_i with stop_i low, SHALL latch period_i and burst_i, clear count_o and timeout_o, and enter TRIG.
REQ-022 A latched period below 2 SHALL be clamped to 2.
REQ-023 TRIG: SHALL drive cnv_o high for exactly this one cycle, load the period counter with period-1 and the timeout counter with TIMEOUT_CYC, then enter WAIT_DATA.
REQ-024 First cnv_o SHALL occur in the cycle after start_i is sampled.
REQ-025 Period and timeout counters SHALL decrement every cycle outside IDLE/TRIG and saturate at 0.
REQ-026 WAIT_DATA, on sdi_valid_i: register sdi_data_i to sample_o, pulse sample_valid_o in the next cycle, and increment count_o (wraps modulo 2^BURST_W in continuous mode).
REQ-027 After the sample: IDLE if it is the run's last; else TRIG if the period counter is 0; else GAP.
REQ-028 A sample is last when count reaches a nonzero burst, or when stop is pending; sample_last_o SHALL be asserted with it.
REQ-029 WAIT_DATA, timeout counter 0 with no sdi_valid_i: set timeout_o, enter IDLE, emit no sample.
REQ-030 GAP: enter TRIG when the period counter reaches 0; while data returns in time, cnv_o pulses SHALL be exactly period cycles apart.
REQ-031 stop_i in TRIG or GAP: enter IDLE next cycle (a cnv_o already issued stands); in WAIT_DATA: set stop-pending and finish the current conversion.
REQ-032 start_i while busy_o is high SHALL be ignored; start_i and stop_i together in IDLE: stop wins, stay IDLE.
REQ-033 sdi_valid_i outside WAIT_DATA SHALL be ignored.
REQ-034 Changes to period_i/burst_i mid-run SHALL have no effect until the next start.

Reset
REQ-035 rst high SHALL asynchronously force IDLE, with cnv_o, sample_valid_o, sample_last_o, busy_o, timeout_o = 0, and sample_o, count_o, both counters and stop-pending cleared.
REQ-036 Reset asserted mid-run SHALL abort it with no further cnv_o or sample_valid_o after release until a new start_i.

Structure
REQ-037 FSM state encoding and the minimum-period constant (2) SHALL reside in shared package adc_seq_pkg.
REQ-038 Period and timeout down-counters SHALL be one reusable saturating down-counter sub-module, adc_seq_timer, instantiated twice.

Verification
REQ-039 period=10, burst=3, sdi_valid_i 4 cycles after each cnv_o -> cnv_o at cycles 1, 11, 21; three samples, third with sample_last_o; count_o=3; IDLE.
REQ-040 period=4, data returned 6 cycles after cnv_o -> next cnv_o the cycle after each valid; no sample lost.
REQ-041 burst=0, stop_i asserted in WAIT_DATA -> current sample delivered with sample_last_o=1, then IDLE, no further cnv_o.
REQ-042 TIMEOUT_CYC=255, sdi_valid_i never returned -> timeout_o=1 after 255 cycles, busy_o=0, sample_valid_o never pulses; next start_i clears timeout_o.
REQ-043 rst pulsed during GAP of a burst=5 run -> all outputs 0 immediately, no cnv_o after release until start_i.
REQ-044 period=1 with start_i and stop_i simultaneous in IDLE -> no run; next start_i alone gives cnv_o spacing of 2 cycles.
